mmio_uart_tx: RTL
=================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
Parameters:
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000: word-aligned base of the register window.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 104: clk cycles per serial bit (12 MHz / 115200).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: TX byte FIFO entries; power of two, 2..16.

Ports:
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port write_mem, input, 1: store strobe from the processor.
REQ-007 SHALL have port funct3, input, 3: access size; ignored except that stores use byte lane 0 only.
REQ-008 SHALL have port write_address, input, 32: store address.
REQ-009 SHALL have port write_data, input, 32: store data.
REQ-010 SHALL have port read_address, input, 32: load address.
REQ-011 SHALL have port read_data, output, 32: registered load data.
REQ-012 SHALL have port tx, output, 1: serial line, 8N1, idle high.

Function
REQ-013 SHALL decode three registers at word offsets: BASE+0 TXDATA, BASE+4 STATUS, BASE+8 CTRL. Any other address is unmapped.
REQ-014 SHALL push write_data[7:0] into the FIFO on a posedge where write_mem=1 and write_address=BASE+0.
REQ-015 SHALL accept a push when count<FIFO_DEPTH, or when a pop occurs in the same cycle; with both push and pop, count stays unchanged.
REQ-016 SHALL drop a push that is not accepted and set a sticky overflow flag.
REQ-017 SHALL clear the overflow flag on a store to BASE+4 with write_data[3]=1; other store bits to STATUS are ignored.
REQ-018 SHALL update the CTRL enable bit from write_data[0] on a store to BASE+8; enable resets to 1.
REQ-019 SHALL register read_data on every posedge from read_address, giving one-cycle load latency:
- TXDATA -> 0
- STATUS -> {24'b0, count[3:0], overflow, busy, empty, full}, i.e. bit0 full, bit1 empty, bit2 busy, bit3 overflow, bits7:4 count
- CTRL -> {31'b0, enable}
- unmapped -> 0
REQ-020 SHALL return, for a STATUS read, the state registered before any same-cycle write takes effect.
REQ-021 SHALL implement the transmitter FSM IDLE -> START -> DATA -> STOP -> IDLE with a bit counter 0..CLKS_PER_BIT-1 and a bit index 0..7.
REQ-022 IDLE: tx=1. When enable=1 and the FIFO is non-empty, SHALL pop the head byte into a shift register and enter START on the same edge.
REQ-023 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-024 DATA SHALL drive 8 bits LSB-first, CLKS_PER_BIT cycles each.
REQ-025 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then return to IDLE; back-to-back frames add no extra idle cycle.
REQ-026 busy SHALL be 1 in any state other than IDLE.
REQ-027 Clearing enable mid-frame SHALL let the current frame complete; no new frame starts until enable=1.
REQ-028 SHALL implement the FIFO with wrapping read/write pointers and a count of width clog2(FIFO_DEPTH)+1; full = (count==FIFO_DEPTH), empty = (count==0).
REQ-029 SHALL ignore stores to TXDATA, STATUS or CTRL with write_mem=0, and stores to unmapped addresses.

Reset
REQ-030 While reset=1, SHALL immediately (asynchronously) force:
- tx=1, FSM=IDLE, FIFO pointers and count=0
- overflow=0, enable=1, read_data=0
REQ-031 Reset asserted mid-frame SHALL abort the frame and discard all queued bytes; after deassertion nothing is transmitted until a new push.

Verification
REQ-032 Push 8'hA5 with CLKS_PER_BIT=4 -> tx low for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4 cycles; STATUS reads busy=1 during the frame and empty=1, busy=0 after.
REQ-033 With enable=0, push 9 bytes into FIFO_DEPTH=8 -> STATUS=8'h89 (count 8, overflow, full); store 32'h8 to STATUS -> STATUS=8'h81.
REQ-034 Full FIFO with FSM popping on the same edge as a push -> push accepted, count remains 8, overflow stays 0.
REQ-035 Push 8'h55, 8'h0F back-to-back -> the second start bit begins the cycle after the first stop bit ends.
REQ-036 Assert reset during DATA bit 3 -> tx=1 within the same cycle; STATUS reads 8'h02 after release; tx stays high.
REQ-037 Read the unmapped address BASE+12 -> read_data=0 one cycle later; read CTRL after reset -> 32'h1.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO fed by CPU stores, STATUS/CTRL
// registers with registered one-cycle load latency, and a start/data/stop serializer.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_mem,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [31:0] A_TXDATA = BASE_ADDR;
  localparam logic [31:0] A_STATUS = BASE_ADDR + 32'd4;
  localparam logic [31:0] A_CTRL   = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_nx;
  logic [BW-1:0]   r_clk_cnt, w_clk_cnt_nx;
  logic [2:0]      r_bit_idx, w_bit_idx_nx;
  logic [7:0]      r_shift, w_shift_nx;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf, r_enable;

  logic w_full, w_empty, w_busy, w_pop, w_push_req, w_push_acc;
  logic w_st_wr, w_ct_wr, w_cnt_last, w_pop_ok, w_tx;
  logic [7:0] w_cnt8;
  logic w_unused;

  assign w_full     = (r_count == DEPTH_C);
  assign w_empty    = (r_count == '0);
  assign w_busy     = (r_state != S_IDLE);
  assign w_push_req = write_mem && (write_address == A_TXDATA);
  assign w_push_acc = w_push_req && (!w_full || w_pop);
  assign w_st_wr    = write_mem && (write_address == A_STATUS);
  assign w_ct_wr    = write_mem && (write_address == A_CTRL);
  assign w_cnt_last = (r_clk_cnt == BIT_LAST);
  assign w_pop_ok   = r_enable && !w_empty;
  assign w_cnt8     = 8'(r_count);
  assign w_unused   = ^{funct3, write_data[31:8], w_cnt8[7:4]};
  assign tx         = w_tx;

  // The last STOP cycle may chain straight into the next START so
  // back-to-back frames carry no idle gap.
  always_comb begin
    w_state_nx   = r_state;
    w_clk_cnt_nx = r_clk_cnt;
    w_bit_idx_nx = r_bit_idx;
    w_shift_nx   = r_shift;
    w_pop        = 1'b0;
    w_tx         = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_pop_ok) begin
          w_pop        = 1'b1;
          w_shift_nx   = r_mem[r_rd_ptr];
          w_state_nx   = S_START;
          w_clk_cnt_nx = '0;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_cnt_last) begin
          w_state_nx   = S_DATA;
          w_clk_cnt_nx = '0;
          w_bit_idx_nx = '0;
        end else begin
          w_clk_cnt_nx = r_clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (w_cnt_last) begin
          w_clk_cnt_nx = '0;
          w_shift_nx   = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) w_state_nx = S_STOP;
          else                   w_bit_idx_nx = r_bit_idx + 1'b1;
        end else begin
          w_clk_cnt_nx = r_clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_cnt_last) begin
          w_clk_cnt_nx = '0;
          if (w_pop_ok) begin
            w_pop      = 1'b1;
            w_shift_nx = r_mem[r_rd_ptr];
            w_state_nx = S_START;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_clk_cnt_nx = r_clk_cnt + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_enable  <= 1'b1;
    end else begin
      r_state   <= w_state_nx;
      r_clk_cnt <= w_clk_cnt_nx;
      r_bit_idx <= w_bit_idx_nx;
      r_shift   <= w_shift_nx;
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push_acc)   r_ovf <= 1'b1;
      else if (w_st_wr && write_data[3]) r_ovf <= 1'b0;
      if (w_ct_wr) r_enable <= write_data[0];
    end
  end

  // When full with a same-edge pop, the write lands in the slot being read;
  // the pop captures the old byte because both use the pre-edge value.
  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[r_wr_ptr] <= write_data[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= '0;
    end else begin
      case (read_address)
        A_STATUS: read_data <= {24'b0, w_cnt8[3:0], r_ovf, w_busy, w_empty, w_full};
        A_CTRL:   read_data <= {31'b0, r_enable};
        default:  read_data <= '0;
      endcase
    end
  end
endmodule
